product_accumulator: RTL and testbench

- Downstream consumer of the shift-and-add multiplier's 16-bit unsigned products.
- Accumulates LEN consecutive products into one dot-product sum, with saturation and a sticky overflow flag.
- Presents each sum on a valid/ready output port and back-pressures the multiplier side while a result is unconsumed.
- Sits between the multiplier and the result FIFO/bus interface.

---
 rtl/product_accumulator.sv | 116 +++++++++++
 tb/tb_product_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Dot-product accumulator: sums LEN unsigned products with saturation and a sticky
// overflow flag, then holds the result on a valid/ready port until it is consumed.
module product_accumulator #(
  parameter int PW  = 16,
  parameter int AW  = 24,
  parameter int LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic          busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] acc_reg;
  logic [CW-1:0] cnt_reg;
  logic          ovf_reg;

  logic [AW-1:0] prod_ext;
  logic [AW:0]   sum_ext;
  logic [AW-1:0] acc_next;
  logic          ovf_next;
  logic [CW-1:0] cnt_next;

  // Saturated sum of the running accumulator and the incoming product. Once acc is
  // all-ones any further addition either carries out or adds zero, so it stays pinned.
  always_comb begin
    prod_ext = AW'(in_prod);
    sum_ext  = (AW + 1)'(acc_reg) + (AW + 1)'(in_prod);
    acc_next = sum_ext[AW] ? {AW{1'b1}} : sum_ext[AW-1:0];
    ovf_next = ovf_reg | sum_ext[AW];
    cnt_next = cnt_reg + 1'b1;
  end

  // in_ready and busy decode the state register only; no input reaches them.
  assign in_ready = (state_reg != HOLD);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg <= prod_ext;
            cnt_reg <= CW'(1);
            ovf_reg <= 1'b0;
            if (LEN == 1) begin
              state_reg <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= prod_ext;
              out_ovf   <= 1'b0;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_next;
            if (cnt_next == LEN_C) begin
              state_reg <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_next;
              out_ovf   <= ovf_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulator builds (default, AW=17, LEN=1) with shared stimulus and
// compares each against a vector-level reference: clamp(sum of LEN accepted products).
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_prod;
  logic [2:0]  in_ready, out_valid, out_ovf, busy;
  logic [23:0] sum_a, sum_c;
  logic [16:0] sum_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PW(16), .AW(24), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_prod(in_prod), .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(sum_a),
    .out_ovf(out_ovf[0]), .busy(busy[0]));

  product_accumulator #(.PW(16), .AW(17), .LEN(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_prod(in_prod), .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(sum_b),
    .out_ovf(out_ovf[1]), .busy(busy[1]));

  product_accumulator #(.PW(16), .AW(24), .LEN(1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_prod(in_prod), .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(sum_c),
    .out_ovf(out_ovf[2]), .busy(busy[2]));

  // Reference state per build: accepted beats and running (unclamped) total.
  int    m_len [3] = '{4, 4, 1};
  longint m_max[3] = '{64'h00FF_FFFF, 64'h0001_FFFF, 64'h00FF_FFFF};
  bit    m_hold[3];
  int    m_cnt [3];
  longint m_tot[3];
  longint m_sum[3];
  bit    m_ovf [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       sum_of = 32'(sum_a);
      1:       sum_of = 32'(sum_b);
      default: sum_of = 32'(sum_c);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hold[k] = 1'b0;
      m_cnt[k]  = 0;
      m_tot[k]  = 0;
    end
  endtask

  // One clock: check visible outputs, apply inputs, advance model across the edge.
  task automatic step(input bit v, input logic [15:0] p, input bit r, input bit c);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("dut%0d in_ready", k), 32'(in_ready[k]), 32'(!m_hold[k]));
      check_eq($sformatf("dut%0d out_valid", k), 32'(out_valid[k]), 32'(m_hold[k]));
      check_eq($sformatf("dut%0d busy", k), 32'(busy[k]), 32'(m_hold[k] || m_cnt[k] > 0));
      if (m_hold[k]) begin
        check_eq($sformatf("dut%0d out_sum", k), sum_of(k), 32'(m_sum[k]));
        check_eq($sformatf("dut%0d out_ovf", k), 32'(out_ovf[k]), 32'(m_ovf[k]));
      end
    end
    in_valid  = v;
    in_prod   = p;
    out_ready = r;
    clear     = c;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_hold[k] = 1'b0;
        m_cnt[k]  = 0;
        m_tot[k]  = 0;
      end else if (m_hold[k]) begin
        if (r) begin
          m_hold[k] = 1'b0;
          $display("dut%0d result sum=0x%0h ovf=%0d", k, m_sum[k], m_ovf[k]);
        end
      end else if (v) begin
        m_cnt[k]++;
        m_tot[k] += longint'(p);
        if (m_cnt[k] == m_len[k]) begin
          m_ovf[k]  = (m_tot[k] > m_max[k]);
          m_sum[k]  = m_ovf[k] ? m_max[k] : m_tot[k];
          m_hold[k] = 1'b1;
          m_cnt[k]  = 0;
          m_tot[k]  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset sum_a", 32'(sum_a), 32'h0);
    check_eq("reset sum_b", 32'(sum_b), 32'h0);
    check_eq("reset out_ovf", 32'(out_ovf), 32'h0);
    check_eq("reset out_valid", 32'(out_valid), 32'h0);
    check_eq("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Back-to-back vector 3,5,7,9 with out_ready high.
    step(1, 16'd3, 1, 0); step(1, 16'd5, 1, 0); step(1, 16'd7, 1, 0); step(1, 16'd9, 1, 0);
    step(1, 16'd11, 1, 0); step(0, 16'd0, 1, 0); step(0, 16'd0, 1, 0); step(0, 16'd0, 1, 0);
    step(0, 16'd0, 1, 0);

    // Bubbles inside a vector.
    step(1, 16'h0010, 1, 0); step(0, 16'h0000, 1, 0); step(1, 16'h0020, 1, 0);
    step(0, 16'h0000, 1, 0); step(0, 16'h0000, 1, 0); step(1, 16'h0030, 1, 0);
    step(1, 16'h0040, 1, 0); step(0, 16'h0000, 1, 0); step(0, 16'h0000, 1, 0);

    // Backpressure: hold the result while the producer keeps offering.
    step(1, 16'd1, 0, 0); step(1, 16'd2, 0, 0); step(1, 16'd3, 0, 0); step(1, 16'd4, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'd100, 0, 0);
    step(1, 16'd100, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 16'd6, 1, 0);
    step(0, 16'd0, 1, 0); step(0, 16'd0, 1, 0);

    // Saturation in the narrow build, then a clean vector.
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 1, 0);
    step(0, 16'd0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 16'd1, 1, 0);
    step(0, 16'd0, 1, 0); step(0, 16'd0, 1, 0);

    // Clear mid-vector, then clear while holding with out_ready high.
    step(1, 16'h0100, 1, 0); step(1, 16'h0200, 1, 0); step(1, 16'h0300, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 16'd1, 0, 0);
    step(0, 16'd0, 0, 0);
    step(0, 16'd0, 1, 1);
    step(0, 16'd0, 1, 0); step(0, 16'd0, 1, 0);

    // Asynchronous reset between edges while a result is held.
    for (int i = 0; i < 4; i++) step(1, 16'd7, 0, 0);
    step(0, 16'd0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("async rst out_valid", 32'(out_valid), 32'h0);
    check_eq("async rst busy", 32'(busy), 32'h0);
    check_eq("async rst in_ready", 32'(in_ready), 32'h7);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 16'd0, 1, 0);

    // Randomized traffic with bubbles, backpressure, occasional clear and big products.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] p;
      p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(0, 1) == 0) p = p & 16'h00FF;
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 16'd0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
